// File: rtl/dmem_lsu.sv
// Load/store unit: aligns core loads/stores onto a handshaked word bus and
// holds the core with Stall while the bus transaction is outstanding.
module dmem_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Fault,
  output logic        BusErr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    off_q;
  logic [1:0]    size_q;
  logic          uns_q;

  logic          req_c;
  logic          illegal_c;
  logic          misalign_c;
  logic          start_c;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;
  logic [31:0]   shifted_c;
  logic [31:0]   ext_c;

  assign req_c = MemRead | MemWrite;

  // Command legality: loads and stores have different Funct3 sets
  always_comb begin
    illegal_c = 1'b0;
    if (MemRead && MemWrite)
      illegal_c = 1'b1;
    else if (MemRead)
      illegal_c = !(Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else if (MemWrite)
      illegal_c = !(Funct3 inside {3'b000, 3'b001, 3'b010});
  end

  assign misalign_c = ((Funct3[1:0] == 2'b01) && Addr[0]) ||
                      ((Funct3[1:0] == 2'b10) && (Addr[1:0] != 2'b00));

  assign start_c = (state == IDLE) && req_c && !illegal_c && !misalign_c;
  assign Fault   = (state == IDLE) && req_c && (illegal_c || misalign_c);
  assign Stall   = start_c || (state == ACCESS);

  // Byte enables and lane-replicated store data
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = WriteData;
    case (Funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << Addr[1:0];
        wdata_c = {4{WriteData[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << Addr[1:0];
        wdata_c = {2{WriteData[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = WriteData;
      end
    endcase
  end

  // Load extraction from the returned word using the captured offset/size
  assign shifted_c = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    ext_c = bus_rdata;
    case (size_q)
      2'b00:   ext_c = uns_q ? {24'b0, shifted_c[7:0]}
                             : {{24{shifted_c[7]}}, shifted_c[7:0]};
      2'b01:   ext_c = uns_q ? {16'b0, shifted_c[15:0]}
                             : {{16{shifted_c[15]}}, shifted_c[15:0]};
      default: ext_c = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      off_q     <= 2'b00;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      ReadData  <= '0;
      BusErr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          BusErr <= 1'b0;
          if (start_c) begin
            state     <= ACCESS;
            cnt       <= '0;
            bus_req   <= 1'b1;
            bus_we    <= MemWrite;
            bus_addr  <= {Addr[31:2], 2'b00};
            bus_be    <= be_c;
            bus_wdata <= wdata_c;
            off_q     <= Addr[1:0];
            size_q    <= Funct3[1:0];
            uns_q     <= Funct3[2];
          end
        end
        ACCESS: begin
          cnt <= cnt + CW'(1);
          if (bus_ack) begin
            if (!bus_we)
              ReadData <= ext_c;
            bus_req <= 1'b0;
            state   <= DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            bus_req  <= 1'b0;
            ReadData <= '0;
            BusErr   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          // The request still presented here is the finished instruction
          BusErr <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit between the single-cycle core datapath and a handshaked data-memory bus. It consumes the datapath's ALUResult (address) and WriteData on loads and stores. It performs byte-lane alignment, byte enables, load sign/zero extension and misalignment checking. It returns the extended ReadData to the datapath's result mux and holds the core via Stall while a bus transaction is outstanding.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles waiting for bus_ack before abort; 8-bit counter, legal range 1-255.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- MemRead  in  1  current instruction is a load
- MemWrite  in  1  current instruction is a store
- Funct3  in  3  Instr[14:12], access size and signedness
- Addr  in  32  byte address (datapath ALUResult)
- WriteData  in  32  store data (datapath WriteData)
- ReadData  out  32  extended load data to the result mux
- Stall  out  1  core must hold PC and suppress RegWrite
- Fault  out  1  misaligned access or illegal Funct3/command (combinational)
- BusErr  out  1  one-cycle pulse: transaction aborted by timeout
- bus_req  out  1  registered request
- bus_we  out  1  1 = write
- bus_addr  out  32  {Addr[31:2], 2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  one-cycle completion strobe
- bus_rdata  in  32  read data, valid with bus_ack

## Operation
- Encodings:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other Funct3 is illegal.
  - MemRead and MemWrite both high is illegal.
- Misalignment: halfword with Addr[0]=1; word with Addr[1:0]≠0.
- Fault = (MemRead|MemWrite) & (illegal | misaligned), evaluated only in IDLE.
  - On Fault: no bus request and Stall low, so the core traps or advances.
- Byte enables:
  - Byte: 0001 << Addr[1:0].
  - Half: 0011 << Addr[1:0].
  - Word: 1111.
  - Loads drive bus_be the same way.
- bus_wdata:
  - Byte: WriteData[7:0] replicated ×4.
  - Half: WriteData[15:0] replicated ×2.
  - Word: unchanged.
- Load extraction: select the byte or half at Addr[1:0] from the captured word. Sign-extend for LB/LH; zero-extend for LBU/LHU.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE → ACCESS on a legal MemRead or MemWrite. Register bus_req=1, bus_we, bus_addr, bus_be and bus_wdata; clear the counter.
  - ACCESS:
    - Hold all bus outputs stable and increment the counter.
    - On bus_ack: capture extended data into the ReadData register, drop bus_req, go to DONE.
    - If the counter reaches TIMEOUT with no ack: drop bus_req, load ReadData=0, pulse BusErr, go to DONE.
  - DONE → IDLE unconditionally. The request still visible in DONE belongs to the finished instruction and must not restart.
- Stall = (IDLE & legal request) | ACCESS. Stall is low in DONE.
- bus_ack outside ACCESS is ignored.
- ReadData holds its last value except on capture.

## Timing
- Reset values: state IDLE, bus_req 0, bus_we 0, bus_addr 0, bus_be 0, bus_wdata 0, ReadData 0, BusErr 0, counter 0.
- With no request in IDLE: Stall 0 and Fault 0.
- Request presented in cycle T: Stall high in T, bus_req high from T+1.
- ack in cycle A ≥ T+1: ReadData valid and Stall low in A+1 (DONE), so the core writes back at the A+1 edge. IDLE at A+2.
- Zero-wait memory (ack in T+1): total stall of 2 cycles, instruction completes at the end of T+2.
- Timeout: BusErr high for exactly the DONE cycle, at T+1+TIMEOUT.
- Reset asserted mid-ACCESS: IDLE and bus_req 0 on the next edge. A subsequent ack is ignored, and no BusErr.
- Non-memory instructions in IDLE: Stall 0, zero latency.

## Test plan
- LW at 0x100, ack at T+1 with rdata 0xDEADBEEF:
  - bus_be 1111 and bus_addr 0x100.
  - Stall high for T and T+1; ReadData 0xDEADBEEF at T+2.
- LB at 0x103 with rdata 0x80112233 → bus_be 1000, ReadData 0xFFFFFF80. Repeat as LBU → ReadData 0x00000080.
- SH at 0x202 with WriteData 0x1234ABCD → bus_we 1, bus_addr 0x200, bus_be 1100, bus_wdata 0xABCDABCD.
- LW at 0x101 → Fault 1, Stall 0, bus_req stays 0. Same for MemRead & MemWrite with a legal address, and for Funct3=011 load.
- LH at 0x40 with no ack and TIMEOUT=4 → bus_req high for 4 cycles, then BusErr pulses for one cycle, ReadData 0, Stall low in that cycle.
- SW in progress, reset in the second ACCESS cycle, ack one cycle later → all outputs at reset values, no capture, no BusErr. The next LW then proceeds normally.
